// File: rtl/zxw_alu_seq_unit.sv
// Sequential ALU: logic and arithmetic ops finish in one cycle. Shifts move one bit
// per cycle in a working register and are published only when the shift is finished.
module zxw_alu_seq_unit #(
  parameter int WIDTH = 8,
  parameter int SW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       fs,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero
);

  // Handshake: start is sampled only while busy=0. done is high for exactly one
  // cycle, and in that cycle result, cout and zero already carry the new value.
  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_work;
  logic [SW-1:0]    r_cnt;
  logic             r_dir;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_zero;
  logic             r_done;

  logic [SW-1:0]    w_shamt;
  logic             w_is_shift;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_cout;
  logic [WIDTH-1:0] w_shift_next;
  logic             w_shift_out;

  assign w_shamt    = b[SW-1:0];
  assign w_is_shift = (fs[2:1] == 2'b11);
  assign w_sum      = {1'b0, a} + {1'b0, b};
  assign w_diff     = {1'b0, a} - {1'b0, b};

  // Single-cycle datapath; a shift by zero simply passes A through.
  always_comb begin
    w_alu_res  = '0;
    w_alu_cout = 1'b0;
    case (fs)
      3'b000: w_alu_res = a & b;
      3'b001: w_alu_res = a | b;
      3'b010: w_alu_res = a ^ b;
      3'b011: w_alu_res = ~a;
      3'b100: begin
        w_alu_res  = w_sum[WIDTH-1:0];
        w_alu_cout = w_sum[WIDTH];
      end
      3'b101: begin
        w_alu_res  = w_diff[WIDTH-1:0];
        w_alu_cout = ~w_diff[WIDTH];
      end
      default: w_alu_res = a;
    endcase
  end

  // r_dir: 1 = shift right, 0 = shift left.
  assign w_shift_next = r_dir ? {1'b0, r_work[WIDTH-1:1]} : {r_work[WIDTH-2:0], 1'b0};
  assign w_shift_out  = r_dir ? r_work[0] : r_work[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_work   <= '0;
      r_cnt    <= '0;
      r_dir    <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_zero   <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (w_is_shift && (w_shamt != '0)) begin
              r_work  <= a;
              r_cnt   <= w_shamt;
              r_dir   <= fs[0];
              r_state <= ST_SHIFT;
            end else begin
              r_result <= w_alu_res;
              r_cout   <= w_alu_cout;
              r_zero   <= (w_alu_res == '0);
              r_done   <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          // start is ignored here; the last shift commits straight to the outputs.
          r_work <= w_shift_next;
          r_cnt  <= r_cnt - SW'(1);
          if (r_cnt == SW'(1)) begin
            r_state  <= ST_IDLE;
            r_result <= w_shift_next;
            r_cout   <= w_shift_out;
            r_zero   <= (w_shift_next == '0);
            r_done   <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy   = (r_state == ST_SHIFT);
  assign done   = r_done;
  assign result = r_result;
  assign cout   = r_cout;
  assign zero   = r_zero;

endmodule

// File: tb/tb_zxw_alu_seq_unit.sv
// Directed bench for zxw_alu_seq_unit (WIDTH=8, SW=3): vector table plus
// hand-written sequences for ignore, reset-abort and back-to-back behaviour.
module tb_zxw_alu_seq_unit;

  localparam int WIDTH = 8;
  localparam int SW    = 3;

  logic             clk;
  logic             rst;
  logic             start;
  logic [2:0]       fs;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             zero;

  int n_total = 0;
  int n_pass  = 0;

  zxw_alu_seq_unit #(.WIDTH(WIDTH), .SW(SW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .fs    (fs),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .result(result),
    .cout  (cout),
    .zero  (zero)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]       fs;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] exp_res;
    logic             exp_cout;
    int               exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      n_pass++;
  endtask

  // Drives one op; called #1 after a rising edge. Returns latency in cycles
  // (1 = done in the cycle after the start edge) and busy cycles observed.
  task automatic run_op(input logic [2:0] f, input logic [WIDTH-1:0] va,
                        input logic [WIDTH-1:0] vb, output int lat, output int bcnt);
    start = 1'b1; fs = f; a = va; b = vb;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom_range(0, 255); b = $urandom_range(0, 255);
    lat = 1; bcnt = 0;
    while (!done && lat < 20) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic add_vec(input logic [2:0] f, input logic [7:0] va, input logic [7:0] vb,
                         input logic [7:0] r, input logic c, input int l);
    vec_t v;
    v.fs = f; v.a = va; v.b = vb; v.exp_res = r; v.exp_cout = c; v.exp_lat = l;
    vecs.push_back(v);
  endtask

  initial begin
    int lat, bcnt, dcnt;
    logic [WIDTH-1:0] held;

    add_vec(3'b000, 8'hF0, 8'h3C, 8'h30, 1'b0, 1);
    add_vec(3'b001, 8'h0F, 8'h30, 8'h3F, 1'b0, 1);
    add_vec(3'b010, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1);
    add_vec(3'b011, 8'h00, 8'h55, 8'hFF, 1'b0, 1);
    add_vec(3'b100, 8'hFF, 8'h01, 8'h00, 1'b1, 1);
    add_vec(3'b100, 8'h12, 8'h34, 8'h46, 1'b0, 1);
    add_vec(3'b101, 8'h03, 8'h05, 8'hFE, 1'b0, 1);
    add_vec(3'b101, 8'h05, 8'h03, 8'h02, 1'b1, 1);
    add_vec(3'b101, 8'h07, 8'h07, 8'h00, 1'b1, 1);
    add_vec(3'b110, 8'h81, 8'h03, 8'h08, 1'b0, 4);
    add_vec(3'b111, 8'h81, 8'h01, 8'h40, 1'b1, 2);
    add_vec(3'b110, 8'hA5, 8'h00, 8'hA5, 1'b0, 1);
    add_vec(3'b111, 8'h3C, 8'h08, 8'h3C, 1'b0, 1);
    add_vec(3'b111, 8'h80, 8'h07, 8'h01, 1'b0, 8);
    add_vec(3'b110, 8'hFF, 8'h07, 8'h80, 1'b1, 8);

    rst = 1'b1; start = 1'b0; fs = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", 32'(result), 32'd0);
    chk("reset_cout", 32'(cout), 32'd0);
    chk("reset_zero", 32'(zero), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_op(vecs[i].fs, vecs[i].a, vecs[i].b, lat, bcnt);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("v%0d_busy_cycles", i), 32'(bcnt), 32'(vecs[i].exp_lat - 1));
      chk($sformatf("v%0d_result", i), 32'(result), 32'(vecs[i].exp_res));
      chk($sformatf("v%0d_cout", i), 32'(cout), 32'(vecs[i].exp_cout));
      chk($sformatf("v%0d_zero", i), 32'(zero), 32'(vecs[i].exp_res == 8'h00));
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_single", i), 32'(done), 32'd0);
      chk($sformatf("v%0d_result_hold", i), 32'(result), 32'(vecs[i].exp_res));
    end

    // start during busy must be ignored
    start = 1'b1; fs = 3'b110; a = 8'h81; b = 8'h03;
    @(posedge clk); #1;
    fs = 3'b000; a = 8'hFF; b = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0;
    dcnt = 0; held = '0;
    for (int k = 0; k < 8; k++) begin
      if (done) begin dcnt++; held = result; end
      @(posedge clk); #1;
    end
    chk("ignore_done_count", 32'(dcnt), 32'd1);
    chk("ignore_result", 32'(held), 32'h08);
    chk("ignore_result_hold", 32'(result), 32'h08);

    // reset in the second SHIFT cycle aborts without a done pulse
    start = 1'b1; fs = 3'b110; a = 8'h81; b = 8'h03;
    @(posedge clk); #1;
    start = 1'b0;
    chk("abort_busy_first", 32'(busy), 32'd1);
    @(posedge clk); #1;
    chk("abort_busy_second", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_result", 32'(result), 32'h00);
    chk("abort_zero", 32'(zero), 32'd1);
    dcnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (done) dcnt++;
      @(posedge clk); #1;
    end
    chk("abort_no_done", 32'(dcnt), 32'd0);

    run_op(3'b000, 8'hF0, 8'h3C, lat, bcnt);
    chk("post_reset_latency", 32'(lat), 32'd1);
    chk("post_reset_result", 32'(result), 32'h30);
    @(posedge clk); #1;

    // new start accepted in the done cycle
    start = 1'b1; fs = 3'b100; a = 8'h12; b = 8'h34;
    @(posedge clk); #1;
    chk("b2b_first_done", 32'(done), 32'd1);
    chk("b2b_first_result", 32'(result), 32'h46);
    fs = 3'b011; a = 8'h00; b = 8'h00;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_second_done", 32'(done), 32'd1);
    chk("b2b_second_result", 32'(result), 32'hFF);
    chk("b2b_second_zero", 32'(zero), 32'd0);
    @(posedge clk); #1;
    chk("b2b_done_drop", 32'(done), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
